// File: rtl/top_level_dec_pkg.sv
// Shared definitions for the RSA datapath: FSM state encoding and default operand width.
// The encryption top imports the same package, so both sides agree on both.
package top_level_dec_pkg;

    localparam int RSA_WIDTH = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SQR   = 3'd2,
        ST_MUL   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/top_level_dec_modmul.sv
// Interleaved shift-add modular multiplier: result = a*b mod n, one bit of b per cycle, MSB first.
// done is high during the last iteration; result shows the final value then and is held afterwards.
module rsa_modmul
    import top_level_dec_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_q, b_q, n_q, acc, red;
    logic [CW-1:0]    cnt;
    logic             running;
    logic [WIDTH+1:0] nx, t, t1;

    // acc < n always, so t = 2*acc + a < 3n: two conditional subtractions suffice
    always_comb begin
        nx  = {2'b00, n_q};
        t   = {1'b0, acc, 1'b0} + (b_q[cnt] ? {2'b00, a_q} : '0);
        t1  = (t >= nx) ? t - nx : t;
        red = WIDTH'((t1 >= nx) ? t1 - nx : t1);
    end

    assign done   = running && (cnt == '0);
    assign result = done ? red : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            a_q     <= a;
            b_q     <= b;
            n_q     <= n;
            acc     <= '0;
            cnt     <= CW'(WIDTH - 1);
            running <= 1'b1;
        end else if (running) begin
            acc <= red;
            cnt <= cnt - 1'b1;
            if (cnt == '0)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/top_level_dec.sv
// RSA decryption top: message = ciphertext^d_key mod n via left-to-right square-and-multiply.
// Every exponent bit is visited, so latency depends only on popcount(d_key).
module top_level_dec
    import top_level_dec_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] ciphertext,
    input  logic [WIDTH-1:0] d_key,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] message,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] c_q, d_q, n_q, r;
    logic [IW-1:0]    idx;
    logic             bad;
    logic             mm_start, mm_done;
    logic [WIDTH-1:0] mm_b, mm_res;

    // operands are sampled by the multiplier only on its start cycle
    assign mm_b = (state == ST_MUL) ? c_q : r;

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk    (clk),
        .reset  (reset),
        .start  (mm_start),
        .a      (r),
        .b      (mm_b),
        .n      (n_q),
        .done   (mm_done),
        .result (mm_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            c_q      <= '0;
            d_q      <= '0;
            n_q      <= '0;
            r        <= '0;
            idx      <= '0;
            bad      <= 1'b0;
            mm_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            message  <= '0;
            err      <= 1'b0;
        end else begin
            done     <= 1'b0;
            mm_start <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    c_q   <= ciphertext;
                    d_q   <= d_key;
                    n_q   <= n;
                    idx   <= IW'(WIDTH - 1);
                    r     <= WIDTH'(1);
                    bad   <= 1'b0;
                    busy  <= 1'b1;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (n_q == '0 || c_q >= n_q) begin
                        bad   <= 1'b1;
                        state <= ST_FIN;
                    end else if (n_q == WIDTH'(1)) begin
                        r     <= '0;
                        state <= ST_FIN;
                    end else begin
                        mm_start <= 1'b1;
                        state    <= ST_SQR;
                    end
                end
                ST_SQR: if (mm_done) begin
                    r <= mm_res;
                    if (d_q[idx]) begin
                        mm_start <= 1'b1;
                        state    <= ST_MUL;
                    end else if (idx == '0) begin
                        state <= ST_FIN;
                    end else begin
                        idx      <= idx - 1'b1;
                        mm_start <= 1'b1;
                        state    <= ST_SQR;
                    end
                end
                ST_MUL: if (mm_done) begin
                    r <= mm_res;
                    if (idx == '0) begin
                        state <= ST_FIN;
                    end else begin
                        idx      <= idx - 1'b1;
                        mm_start <= 1'b1;
                        state    <= ST_SQR;
                    end
                end
                ST_FIN: begin
                    message <= bad ? '0 : r;
                    err     <= bad;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level_dec.sv
// Directed bench for top_level_dec: 8-bit hand-computed vectors plus a few 128-bit runs vs a model.
module tb_top_level_dec;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         start8 = 1'b0;
    logic [7:0]   c8 = '0, d8 = '0, n8 = '0, msg8;
    logic         busy8, done8, err8;

    logic         start128 = 1'b0;
    logic [127:0] c128 = '0, d128 = '0, n128 = '0, msg128;
    logic         busy128, done128, err128;

    int n_chk = 0;
    int n_err = 0;

    top_level_dec #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ciphertext(c8), .d_key(d8), .n(n8),
        .busy(busy8), .done(done8), .message(msg8), .err(err8)
    );

    top_level_dec #(.WIDTH(128)) dut128 (
        .clk(clk), .reset(reset), .start(start128), .ciphertext(c128), .d_key(d128), .n(n128),
        .busy(busy128), .done(done128), .message(msg128), .err(err128)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_pow(input logic [127:0] c, d, nn);
        logic [255:0] r = 256'd1;
        for (int i = 127; i >= 0; i--) begin
            r = (r * r) % {128'd0, nn};
            if (d[i]) r = (r * {128'd0, c}) % {128'd0, nn};
        end
        return r[127:0];
    endfunction

    // rst_at: assert reset after that many cycles; poke_at: pulse start while busy
    task automatic run8(input logic [7:0] c, d, nn, input int rst_at, input int poke_at,
                        output int lat);
        int gap = 0;
        @(negedge clk);
        c8 = c; d8 = d; n8 = nn; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            start8 = (i == poke_at);
            if (done8) begin
                lat = i;
                break;
            end
            if (!busy8) gap++;
            if (i == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", busy8, 0);
                chk("rst_done", done8, 0);
                chk("rst_msg", msg8, 0);
                chk("rst_err", err8, 0);
                @(negedge clk);
                reset = 1'b0;
                lat = 0;
                break;
            end
        end
        start8 = 1'b0;
        if (rst_at == 0) begin
            chk("busy_gap", gap, 0);
            chk("busy_at_done", busy8, 0);
            @(posedge clk); #1;
            chk("done_pulse", done8, 0);
        end
    endtask

    task automatic run128(input logic [127:0] c, d, nn, output int lat);
        @(negedge clk);
        c128 = c; d128 = d; n128 = nn; start128 = 1'b1;
        @(posedge clk); #1;
        start128 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40000; i++) begin
            @(posedge clk); #1;
            if (done128) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int extra;
        logic [127:0] c, d, nn;
        logic [127:0] dlist [3];

        #12;
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_msg", msg8, 0);
        chk("reset_err", err8, 0);
        chk("reset_busy128", busy128, 0);
        @(negedge clk);
        reset = 1'b0;

        // basic decrypt: 11^23 mod 187 = 88, popcount(23)=4
        run8(8'd11, 8'd23, 8'd187, 0, 0, lat);
        chk("t1_lat", lat, 110);
        chk("t1_msg", msg8, 88);
        chk("t1_err", err8, 0);

        // zero exponent and zero ciphertext
        run8(8'd50, 8'd0, 8'd187, 0, 0, lat);
        chk("t2_lat", lat, 74);
        chk("t2_msg", msg8, 1);
        run8(8'd0, 8'd23, 8'd187, 0, 0, lat);
        chk("t2b_lat", lat, 110);
        chk("t2b_msg", msg8, 0);

        // illegal operands
        run8(8'd5, 8'd23, 8'd0, 0, 0, lat);
        chk("t3_n0_lat", lat, 2);
        chk("t3_n0_err", err8, 1);
        chk("t3_n0_msg", msg8, 0);
        run8(8'd200, 8'd23, 8'd187, 0, 0, lat);
        chk("t3_cge_lat", lat, 2);
        chk("t3_cge_err", err8, 1);
        chk("t3_cge_msg", msg8, 0);

        // n == 1 is legal; clears the previous err
        run8(8'd0, 8'd5, 8'd1, 0, 0, lat);
        chk("t4_lat", lat, 2);
        chk("t4_err", err8, 0);
        chk("t4_msg", msg8, 0);

        // mid-operation reset, then a full run with a start poked while busy
        run8(8'd11, 8'd23, 8'd187, 0, 0, lat);
        chk("t5_pre_msg", msg8, 88);
        run8(8'd11, 8'd23, 8'd187, 50, 0, lat);
        run8(8'd11, 8'd23, 8'd187, 0, 30, lat);
        chk("t5_lat", lat, 110);
        chk("t5_msg", msg8, 88);
        chk("t5_err", err8, 0);
        extra = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (done8) extra++;
        end
        chk("t5_no_second_done", extra, 0);
        chk("t5_idle_busy", busy8, 0);

        // wide operands against the reference model
        dlist[0] = 128'd65537;
        dlist[1] = 128'd3;
        dlist[2] = {1'b1, 126'd0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            nn = {$urandom(), $urandom(), $urandom(), $urandom()};
            nn[127] = 1'b1;
            nn[0] = 1'b1;
            c = {$urandom(), $urandom(), $urandom(), $urandom()} % nn;
            d = dlist[k];
            run128(c, d, nn, lat);
            chk("t6_msg", msg128, ref_pow(c, d, nn));
            chk("t6_err", err128, 0);
            chk("t6_lat", lat, 2 + (128 + $countones(d)) * 129);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
